// File: rtl/minv_operand_loader.sv
// Streams P, U, V (and X1 in division mode) into the MINV/MDIV datapath, then
// starts the operation and reports completion. Optional macro: MINV_LOADER_ZCHK_EN.
module minv_operand_loader #(
  parameter int DW    = 32,
  parameter int WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_req,
  input  logic          mode_mdiv,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [DW-1:0] datain,
  output logic          mux3_sel,
  output logic          regp_we,
  output logic          regp_cyc,
  output logic          regu_we,
  output logic          regu_cyc,
  output logic          regv_we,
  output logic          regv_cyc,
  output logic          regx1_we,
  output logic          regx1_cyc,
  output logic          minv_en,
  output logic          minv_mdiv,
  input  logic          minv_rdy,
  output logic          busy,
  output logic          done,
  output logic          err_zero
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_P  = 3'd1,
    S_LD_U  = 3'd2,
    S_LD_V  = 3'd3,
    S_LD_X1 = 3'd4,
    S_START = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] datain_q, datain_d;
  // strobe bits: [0]=P, [1]=U, [2]=V, [3]=X1
  logic [3:0]    strb_q, strb_d;
  logic          minv_en_q, minv_en_d;
  logic          done_q, done_d;
  logic          err_zero_q, err_zero_d;
  logic          mdiv_q, mdiv_d;
  logic          xfer_s;
  logic          last_word_s;
  logic          u_zero_s;

`ifdef MINV_LOADER_ZCHK_EN
  logic [DW-1:0] u_or_q, u_or_d;
  assign u_zero_s = (u_or_q == {DW{1'b0}});
`else
  assign u_zero_s = 1'b0;
`endif

  assign s_ready     = (state_q == S_LD_P) || (state_q == S_LD_U) ||
                       (state_q == S_LD_V) || (state_q == S_LD_X1);
  assign xfer_s      = s_valid & s_ready;
  assign last_word_s = (cnt_q == LAST_CNT);

  // Next-state, counter, datain capture and strobe generation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    datain_d   = datain_q;
    strb_d     = 4'b0000;
    minv_en_d  = 1'b0;
    done_d     = 1'b0;
    err_zero_d = 1'b0;
    mdiv_d     = mdiv_q;
`ifdef MINV_LOADER_ZCHK_EN
    u_or_d     = u_or_q;
`endif

    if (xfer_s) begin
      datain_d = s_data;
      if (last_word_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      datain_d = datain_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          mdiv_d  = ~mode_mdiv;
          cnt_d   = {CW{1'b0}};
`ifdef MINV_LOADER_ZCHK_EN
          u_or_d  = {DW{1'b0}};
`endif
          state_d = S_LD_P;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_P: begin
        if (xfer_s) begin
          strb_d = 4'b0001;
          if (last_word_s) state_d = S_LD_U;
          else             state_d = S_LD_P;
        end else begin
          state_d = S_LD_P;
        end
      end
      S_LD_U: begin
        if (xfer_s) begin
          strb_d = 4'b0010;
`ifdef MINV_LOADER_ZCHK_EN
          u_or_d = u_or_q | s_data;
`endif
          if (last_word_s) state_d = S_LD_V;
          else             state_d = S_LD_U;
        end else begin
          state_d = S_LD_U;
        end
      end
      // V is the final operand in inversion mode (mdiv_q=1)
      S_LD_V: begin
        if (xfer_s) begin
          strb_d = 4'b0100;
          if (last_word_s && !mdiv_q) begin
            state_d = S_LD_X1;
          end else if (last_word_s && u_zero_s) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            err_zero_d = 1'b1;
          end else if (last_word_s) begin
            state_d = S_START;
          end else begin
            state_d = S_LD_V;
          end
        end else begin
          state_d = S_LD_V;
        end
      end
      S_LD_X1: begin
        if (xfer_s) begin
          strb_d = 4'b1000;
          if (last_word_s && u_zero_s) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            err_zero_d = 1'b1;
          end else if (last_word_s) begin
            state_d = S_START;
          end else begin
            state_d = S_LD_X1;
          end
        end else begin
          state_d = S_LD_X1;
        end
      end
      S_START: begin
        minv_en_d = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (minv_rdy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      datain_q   <= {DW{1'b0}};
      strb_q     <= 4'b0000;
      minv_en_q  <= 1'b0;
      done_q     <= 1'b0;
      err_zero_q <= 1'b0;
      mdiv_q     <= 1'b1;
`ifdef MINV_LOADER_ZCHK_EN
      u_or_q     <= {DW{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      datain_q   <= datain_d;
      strb_q     <= strb_d;
      minv_en_q  <= minv_en_d;
      done_q     <= done_d;
      err_zero_q <= err_zero_d;
      mdiv_q     <= mdiv_d;
`ifdef MINV_LOADER_ZCHK_EN
      u_or_q     <= u_or_d;
`endif
    end
  end

  assign datain    = datain_q;
  assign mux3_sel  = 1'b0;
  assign regp_we   = strb_q[0];
  assign regp_cyc  = strb_q[0];
  assign regu_we   = strb_q[1];
  assign regu_cyc  = strb_q[1];
  assign regv_we   = strb_q[2];
  assign regv_cyc  = strb_q[2];
  assign regx1_we  = strb_q[3];
  assign regx1_cyc = strb_q[3];
  assign minv_en   = minv_en_q;
  assign minv_mdiv = mdiv_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

`ifdef MINV_LOADER_ZCHK_EN
  assign err_zero = err_zero_q;
`else
  // err_zero_q is always 0 in this build; keep it read to avoid a dangling flop
  assign err_zero = err_zero_q & 1'b0;
`endif

endmodule

// File: tb/tb_minv_operand_loader.sv
// Directed bench for minv_operand_loader: inversion, division, stalls, reset,
// ignored start_req and the U==0 path (MINV_LOADER_ZCHK_EN-aware).
module tb_minv_operand_loader;

  logic        clk = 1'b0;
  logic        rst, start_req, mode_mdiv, s_valid, minv_rdy;
  logic [31:0] s_data;
  logic        s_ready, mux3_sel;
  logic [31:0] datain;
  logic        regp_we, regp_cyc, regu_we, regu_cyc, regv_we, regv_cyc;
  logic        regx1_we, regx1_cyc, minv_en, minv_mdiv, busy, done, err_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_last = 32'h0;

  always #5 clk = ~clk;

  minv_operand_loader #(.DW(32), .WORDS(8)) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .mode_mdiv(mode_mdiv),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .datain(datain),
    .mux3_sel(mux3_sel), .regp_we(regp_we), .regp_cyc(regp_cyc),
    .regu_we(regu_we), .regu_cyc(regu_cyc), .regv_we(regv_we), .regv_cyc(regv_cyc),
    .regx1_we(regx1_we), .regx1_cyc(regx1_cyc), .minv_en(minv_en),
    .minv_mdiv(minv_mdiv), .minv_rdy(minv_rdy), .busy(busy), .done(done),
    .err_zero(err_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] strobes();
    return {regx1_cyc, regv_cyc, regu_cyc, regp_cyc, regx1_we, regv_we, regu_we, regp_we};
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_datain"}, datain, 32'h0);
    chk({tag, "_strobes"}, {24'h0, strobes()}, 32'h0);
    chk({tag, "_ctl"}, {27'h0, minv_en, done, err_zero, busy, s_ready}, 32'h0);
    chk({tag, "_mdiv"}, {31'h0, minv_mdiv}, 32'h1);
    chk({tag, "_mux3"}, {31'h0, mux3_sel}, 32'h0);
  endtask

  task automatic begin_op(input logic mode);
    chk("idle_sready", {31'h0, s_ready}, 32'h0);
    start_req = 1'b1;
    mode_mdiv = mode;
    tick();
    start_req = 1'b0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_sready", {31'h0, s_ready}, 32'h1);
    chk("start_mdiv", {31'h0, minv_mdiv}, {31'h0, ~mode});
  endtask

  // n words starting at base; optional 1,0,0 valid pattern; start_req at word sr_at
  task automatic run_load(input int n, input logic [31:0] base, input bit stall,
                          input int sr_at, input logic exp_mdiv, input bit zero_u);
    logic [7:0] exp_strb;
    for (int w = 0; w < n; w++) begin
      if (stall && w > 0) begin
        for (int g = 0; g < 2; g++) begin
          s_valid = 1'b0;
          s_data  = 32'hDEAD_BEEF;
          tick();
          chk("gap_strobes", {24'h0, strobes()}, 32'h0);
          chk("gap_datain", datain, exp_last);
        end
      end
      s_valid   = 1'b1;
      s_data    = (zero_u && w >= 8 && w < 16) ? 32'h0 : base + 32'(w);
      start_req = (w == sr_at);
      mode_mdiv = exp_mdiv;
      chk("ld_sready", {31'h0, s_ready}, 32'h1);
      exp_last  = s_data;
      tick();
      s_valid   = 1'b0;
      start_req = 1'b0;
      exp_strb  = 8'h0;
      exp_strb[w / 8]     = 1'b1;
      exp_strb[w / 8 + 4] = 1'b1;
      chk($sformatf("w%0d_datain", w), datain, exp_last);
      chk($sformatf("w%0d_strobes", w), {24'h0, strobes()}, {24'h0, exp_strb});
      chk("ld_mdiv", {31'h0, minv_mdiv}, {31'h0, exp_mdiv});
      chk("ld_minv_en", {31'h0, minv_en}, 32'h0);
    end
  endtask

  task automatic finish_op(input logic exp_mdiv, input int rdy_delay, input bit sr_in_wait);
    chk("pre_start_done", {31'h0, done}, 32'h0);
    tick();
    chk("start_minv_en", {31'h0, minv_en}, 32'h1);
    chk("start_strobes", {24'h0, strobes()}, 32'h0);
    chk("start_busy2", {31'h0, busy}, 32'h1);
    chk("start_sready0", {31'h0, s_ready}, 32'h0);
    tick();
    chk("minv_en_once", {31'h0, minv_en}, 32'h0);
    for (int d = 0; d < rdy_delay; d++) begin
      start_req = sr_in_wait && (d == 2);
      mode_mdiv = exp_mdiv;
      tick();
      start_req = 1'b0;
      chk("wait_done0", {31'h0, done}, 32'h0);
      chk("wait_busy", {31'h0, busy}, 32'h1);
      chk("wait_minv_en0", {31'h0, minv_en}, 32'h0);
    end
    chk("wait_mdiv", {31'h0, minv_mdiv}, {31'h0, exp_mdiv});
    minv_rdy = 1'b1;
    tick();
    minv_rdy = 1'b0;
    chk("done_pulse", {31'h0, done}, 32'h1);
    chk("done_busy0", {31'h0, busy}, 32'h0);
    chk("done_err0", {31'h0, err_zero}, 32'h0);
    chk("done_mdiv", {31'h0, minv_mdiv}, {31'h0, exp_mdiv});
    tick();
    chk("done_once", {31'h0, done}, 32'h0);
    chk("post_sready", {31'h0, s_ready}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start_req = 1'b0; mode_mdiv = 1'b0; s_valid = 1'b0;
    s_data = 32'h0; minv_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_zero("reset");
    tick();
    check_idle_zero("idle");

    // T1 inversion, back-to-back
    begin_op(1'b0);
    run_load(24, 32'h0, 1'b0, -1, 1'b1, 1'b0);
    finish_op(1'b1, 9, 1'b0);

    // T2 division, X1 loaded after V
    begin_op(1'b1);
    run_load(32, 32'h100, 1'b0, -1, 1'b0, 1'b0);
    finish_op(1'b0, 3, 1'b0);

    // T3 stalls
    begin_op(1'b0);
    run_load(24, 32'h200, 1'b1, -1, 1'b1, 1'b0);
    finish_op(1'b1, 2, 1'b0);

    // T4 reset after word 13, then a clean inversion load
    begin_op(1'b1);
    run_load(14, 32'h400, 1'b0, -1, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h40E;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    check_idle_zero("midreset");
    tick();
    check_idle_zero("midreset2");
    begin_op(1'b0);
    run_load(24, 32'h0, 1'b0, -1, 1'b1, 1'b0);
    finish_op(1'b1, 9, 1'b0);

    // T5 start_req in LD_U (word 10) and in WAIT is ignored
    begin_op(1'b0);
    run_load(24, 32'h500, 1'b0, 10, 1'b1, 1'b0);
    finish_op(1'b1, 5, 1'b1);

    // minv_rdy already high on WAIT entry: WAIT lasts one cycle
    begin_op(1'b0);
    run_load(24, 32'h600, 1'b0, -1, 1'b1, 1'b0);
    tick();
    chk("fast_minv_en", {31'h0, minv_en}, 32'h1);
    minv_rdy = 1'b1;
    tick();
    minv_rdy = 1'b0;
    chk("fast_done", {31'h0, done}, 32'h1);
    chk("fast_busy0", {31'h0, busy}, 32'h0);
    tick();
    chk("fast_done_once", {31'h0, done}, 32'h0);

    // T6 all-zero U
    begin_op(1'b0);
    run_load(24, 32'h700, 1'b0, -1, 1'b1, 1'b1);
`ifdef MINV_LOADER_ZCHK_EN
    chk("zchk_done", {31'h0, done}, 32'h1);
    chk("zchk_err", {31'h0, err_zero}, 32'h1);
    chk("zchk_busy0", {31'h0, busy}, 32'h0);
    tick();
    chk("zchk_done_once", {31'h0, done}, 32'h0);
    chk("zchk_err_once", {31'h0, err_zero}, 32'h0);
    chk("zchk_no_minv_en", {31'h0, minv_en}, 32'h0);
    tick();
    chk("zchk_no_minv_en2", {31'h0, minv_en}, 32'h0);
`else
    chk("nozchk_err0", {31'h0, err_zero}, 32'h0);
    finish_op(1'b1, 2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
